// File: rtl/in_buffer_if.sv
// Stream, read-port and frame-status signals between the upstream source,
// the compute core and in_buffer.
interface in_buffer_if #(
   parameter int IDX_BITS = 2
);
   logic                CLEAR;
   logic [15:0]         DATA_IN;
   logic                D_VALID;
   logic                D_READY;
   logic [IDX_BITS-1:0] RD_IDX;
   logic [15:0]         POS_X;
   logic [15:0]         POS_Y;
   logic                FRAME_VALID;
   logic                CONSUMED;
   logic                CSUM_ERR;

   modport master (
      output CLEAR, DATA_IN, D_VALID, RD_IDX, CONSUMED,
      input  D_READY, POS_X, POS_Y, FRAME_VALID, CSUM_ERR
   );

   modport slave (
      input  CLEAR, DATA_IN, D_VALID, RD_IDX, CONSUMED,
      output D_READY, POS_X, POS_Y, FRAME_VALID, CSUM_ERR
   );
endinterface

// File: rtl/in_buffer.sv
// Particle frame input buffer: collects N (X,Y) pairs from a stream and holds them
// for random-index reads. Define IN_BUFFER_CHECKSUM_EN to add an XOR checksum trailer.
//
// state   | meaning
// S_FILL  | accepting data beats, k counts beats of the current frame
// S_CHECK | expecting the checksum trailer (IN_BUFFER_CHECKSUM_EN only)
// S_FULL  | frame complete and frozen until CONSUMED
module in_buffer #(
   parameter int N        = 4,
   parameter int IDX_BITS = $clog2(N)
) (
   input  logic        CLK_IN,
   input  logic        RESET_IN,
   in_buffer_if.slave  bus
);
   localparam int AW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
`ifdef IN_BUFFER_CHECKSUM_EN
      S_CHECK = 2'd1,
`endif
      S_FULL  = 2'd2
   } state_t;

   state_t              state;
   logic [AW-1:0]       k_idx;
   logic                k_half;
   logic                d_ready;
   logic                frame_valid;
   logic [15:0]         pos_x;
   logic [15:0]         pos_y;
   logic [15:0]         mem_x [N];
   logic [15:0]         mem_y [N];
   logic [IDX_BITS-1:0] rd_idx;
   logic                rd_ok;
   logic                beat;
   logic                last_beat;

   assign rd_idx    = bus.RD_IDX;
   assign rd_ok     = int'(rd_idx) < N;
   assign beat      = bus.D_VALID && d_ready;
   assign last_beat = k_half && (k_idx == AW'(N - 1));

`ifdef IN_BUFFER_CHECKSUM_EN
   logic [15:0] csum;
   logic        csum_err;
`endif

   always_ff @(posedge CLK_IN or negedge RESET_IN) begin
      if (!RESET_IN) begin
         state       <= S_FILL;
         k_idx       <= '0;
         k_half      <= 1'b0;
         d_ready     <= 1'b1;
         frame_valid <= 1'b0;
         pos_x       <= '0;
         pos_y       <= '0;
         for (int i = 0; i < N; i++) begin
            mem_x[i] <= '0;
            mem_y[i] <= '0;
         end
`ifdef IN_BUFFER_CHECKSUM_EN
         csum        <= '0;
         csum_err    <= 1'b0;
`endif
      end else begin
         // read sees the pre-write contents because storage updates on the same edge
         pos_x <= rd_ok ? mem_x[rd_idx[AW-1:0]] : '0;
         pos_y <= rd_ok ? mem_y[rd_idx[AW-1:0]] : '0;

         if (bus.CLEAR) begin
            state       <= S_FILL;
            k_idx       <= '0;
            k_half      <= 1'b0;
            d_ready     <= 1'b1;
            frame_valid <= 1'b0;
`ifdef IN_BUFFER_CHECKSUM_EN
            csum        <= '0;
            csum_err    <= 1'b0;
`endif
         end else begin
            case (state)
               S_FILL: begin
                  if (beat) begin
                     if (!k_half) mem_x[k_idx] <= bus.DATA_IN;
                     else         mem_y[k_idx] <= bus.DATA_IN;
`ifdef IN_BUFFER_CHECKSUM_EN
                     csum <= csum ^ bus.DATA_IN;
`endif
                     if (last_beat) begin
                        k_idx  <= '0;
                        k_half <= 1'b0;
`ifdef IN_BUFFER_CHECKSUM_EN
                        state  <= S_CHECK;
`else
                        state       <= S_FULL;
                        d_ready     <= 1'b0;
                        frame_valid <= 1'b1;
`endif
                     end else begin
                        k_half <= ~k_half;
                        if (k_half) k_idx <= k_idx + 1'b1;
                     end
                  end
               end
`ifdef IN_BUFFER_CHECKSUM_EN
               S_CHECK: begin
                  if (beat) begin
                     csum_err    <= (bus.DATA_IN != csum);
                     csum        <= '0;
                     state       <= S_FULL;
                     d_ready     <= 1'b0;
                     frame_valid <= 1'b1;
                  end
               end
`endif
               S_FULL: begin
                  if (bus.CONSUMED) begin
                     state       <= S_FILL;
                     d_ready     <= 1'b1;
                     frame_valid <= 1'b0;
                  end
               end
               default: begin
                  state       <= S_FILL;
                  k_idx       <= '0;
                  k_half      <= 1'b0;
                  d_ready     <= 1'b1;
                  frame_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.D_READY     = d_ready;
   assign bus.FRAME_VALID = frame_valid;
   assign bus.POS_X       = pos_x;
   assign bus.POS_Y       = pos_y;
`ifdef IN_BUFFER_CHECKSUM_EN
   assign bus.CSUM_ERR    = csum_err;
`else
   assign bus.CSUM_ERR    = 1'b0;
`endif
endmodule
